// File: rtl/chain_mixer_seq.sv
// ---------------------------------------------------------------------------
// chain_mixer_seq
//
// Control sequencer for an N-stage serial chain mixer. Stage i mixes junction
// fluid j[i] with reagent k[i] to produce j[i+1]. For every active stage the
// sequencer runs a FILL phase (junction + reagent inlet open), then a MIX
// phase (stage pump on). After the last stage it runs a DRAIN phase through
// the junction valve that follows that stage. The active chain length and the
// phase durations are captured when a start is accepted.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   start         begin a sequence (only looked at while idle)
//   abort         terminate the running sequence
//   stage_count   number of active stages, 1..STAGES (latched at start)
//   fill_cycles   FILL duration per stage, 0 behaves as 1 (latched at start)
//   mix_cycles    MIX duration per stage, 0 behaves as 1 (latched at start)
//   drain_cycles  final DRAIN duration, 0 behaves as 1 (latched at start)
//   valve_j       junction valves, bit i opens j[i] (one-hot or zero)
//   valve_k       reagent inlet valves, bit i opens k[i] (one-hot or zero)
//   pump_en       mixing pump enables, bit i drives stage i (one-hot or zero)
//   busy          high from the first FILL cycle through DRAIN or ABORT
//   done          single-cycle pulse when a sequence completes normally
//   err           sticky error (bad length or abort); cleared by next start
//   cur_stage     stage being serviced; stage_count during DRAIN; 0 in IDLE
//
// Every output is a register loaded together with the state transition, so
// the actuator pattern of a phase appears in the first cycle of that phase.
// ---------------------------------------------------------------------------
module chain_mixer_seq #(
    parameter int STAGES = 64,
    parameter int CNT_W  = 16,
    parameter int SW     = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SW-1:0]     stage_count,
    input  logic [CNT_W-1:0]  fill_cycles,
    input  logic [CNT_W-1:0]  mix_cycles,
    input  logic [CNT_W-1:0]  drain_cycles,
    output logic [STAGES:0]   valve_j,
    output logic [STAGES-1:0] valve_k,
    output logic [STAGES-1:0] pump_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SW-1:0]     cur_stage
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_MIX,
        S_DRAIN,
        S_ABORT
    } state_t;

    state_t             r_state;
    logic [SW-1:0]      r_stage;
    logic [SW-1:0]      r_count;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_fill_m1;
    logic [CNT_W-1:0]   r_mix_m1;
    logic [CNT_W-1:0]   r_drain_m1;

    logic [STAGES:0]    r_valve_j;
    logic [STAGES-1:0]  r_valve_k;
    logic [STAGES-1:0]  r_pump_en;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [SW-1:0]      r_cur_stage;

    logic [SW-1:0]      w_stage_inc;
    logic               w_len_ok;
    logic               w_running;
    logic [STAGES-1:0]  w_dec_cur;
    logic [STAGES-1:0]  w_dec_nxt;
    logic [STAGES:0]    w_dec_cnt;

    // Counter reload value: a duration of 0 behaves like 1, so both load 0.
    function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    // The last stage index is STAGES-1, so stage+1 never exceeds STAGES and
    // fits in SW bits.
    assign w_stage_inc = r_stage + 1'b1;
    assign w_len_ok    = (stage_count != '0) && (stage_count <= SW'(STAGES));
    assign w_running   = (r_state == S_FILL) || (r_state == S_MIX) ||
                         (r_state == S_DRAIN);

    // One-hot decoders for the current stage, the following stage and the
    // drain junction (index = chain length).
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_dec_stage
            assign w_dec_cur[gi] = (r_stage == SW'(gi));
            assign w_dec_nxt[gi] = (w_stage_inc == SW'(gi));
        end
        for (gi = 0; gi <= STAGES; gi++) begin : g_dec_drain
            assign w_dec_cnt[gi] = (r_count == SW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_stage     <= '0;
            r_count     <= '0;
            r_cnt       <= '0;
            r_fill_m1   <= '0;
            r_mix_m1    <= '0;
            r_drain_m1  <= '0;
            r_valve_j   <= '0;
            r_valve_k   <= '0;
            r_pump_en   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cur_stage <= '0;
        end else begin
            r_done <= 1'b0;
            // Abort wins over a phase that would complete in the same cycle.
            if (w_running && abort) begin
                r_state   <= S_ABORT;
                r_valve_j <= '0;
                r_valve_k <= '0;
                r_pump_en <= '0;
                r_err     <= 1'b1;
                r_busy    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_len_ok) begin
                                r_count      <= stage_count;
                                r_fill_m1    <= f_load(fill_cycles);
                                r_mix_m1     <= f_load(mix_cycles);
                                r_drain_m1   <= f_load(drain_cycles);
                                r_cnt        <= f_load(fill_cycles);
                                r_stage      <= '0;
                                r_cur_stage  <= '0;
                                r_err        <= 1'b0;
                                r_busy       <= 1'b1;
                                r_state      <= S_FILL;
                                r_valve_j    <= '0;
                                r_valve_j[0] <= 1'b1;
                                r_valve_k    <= '0;
                                r_valve_k[0] <= 1'b1;
                                r_pump_en    <= '0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_FILL: begin
                        if (r_cnt == '0) begin
                            r_state   <= S_MIX;
                            r_cnt     <= r_mix_m1;
                            r_valve_j <= '0;
                            r_valve_k <= '0;
                            r_pump_en <= w_dec_cur;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_MIX: begin
                        if (r_cnt == '0) begin
                            r_pump_en <= '0;
                            if (w_stage_inc < r_count) begin
                                r_state     <= S_FILL;
                                r_stage     <= w_stage_inc;
                                r_cur_stage <= w_stage_inc;
                                r_cnt       <= r_fill_m1;
                                r_valve_j   <= {1'b0, w_dec_nxt};
                                r_valve_k   <= w_dec_nxt;
                            end else begin
                                r_state     <= S_DRAIN;
                                r_cur_stage <= r_count;
                                r_cnt       <= r_drain_m1;
                                r_valve_j   <= w_dec_cnt;
                                r_valve_k   <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (r_cnt == '0) begin
                            r_state     <= S_IDLE;
                            r_valve_j   <= '0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_cur_stage <= '0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_ABORT: begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_cur_stage <= '0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign valve_j   = r_valve_j;
    assign valve_k   = r_valve_k;
    assign pump_en   = r_pump_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign cur_stage = r_cur_stage;

endmodule

// File: tb/tb_chain_mixer_seq.sv
// ---------------------------------------------------------------------------
// Testbench for chain_mixer_seq. Each accepted command expands into the full
// per-cycle actuator trace implied by the chain rules (stage after stage of
// fill then mix, then drain, then one done cycle); the trace is queued and a
// monitor compares one queued entry per clock. With the queue empty the
// monitor expects the idle pattern.
// ---------------------------------------------------------------------------
module tb_chain_mixer_seq;

    localparam int STAGES = 64;
    localparam int CNT_W  = 16;
    localparam int SW     = $clog2(STAGES + 1);

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [SW-1:0]     stage_count;
    logic [CNT_W-1:0]  fill_cycles;
    logic [CNT_W-1:0]  mix_cycles;
    logic [CNT_W-1:0]  drain_cycles;
    logic [STAGES:0]   valve_j;
    logic [STAGES-1:0] valve_k;
    logic [STAGES-1:0] pump_en;
    logic              busy;
    logic              done;
    logic              err;
    logic [SW-1:0]     cur_stage;

    chain_mixer_seq #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .stage_count  (stage_count),
        .fill_cycles  (fill_cycles),
        .mix_cycles   (mix_cycles),
        .drain_cycles (drain_cycles),
        .valve_j      (valve_j),
        .valve_k      (valve_k),
        .pump_en      (pump_en),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cur_stage    (cur_stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [STAGES:0]   vj;
        logic [STAGES-1:0] vk;
        logic [STAGES-1:0] pe;
        logic              busy;
        logic              done;
        logic              err;
        int                cur;
        bit                cur_dc;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic idle_err = 1'b0;

    function automatic rec_t idle_rec(input logic e);
        rec_t r;
        r.vj = '0; r.vk = '0; r.pe = '0;
        r.busy = 1'b0; r.done = 1'b0; r.err = e;
        r.cur = 0; r.cur_dc = 1'b0;
        return r;
    endfunction

    // Monitor: one comparison per clock, sampled on the falling edge.
    always @(negedge clk) begin
        rec_t e;
        bit   bad;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = idle_rec(idle_err);
        bad = (valve_j !== e.vj) || (valve_k !== e.vk) || (pump_en !== e.pe) ||
              (busy !== e.busy) || (done !== e.done) || (err !== e.err) ||
              (!e.cur_dc && (int'(cur_stage) != e.cur));
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL outputs t=%0t got vj=%h vk=%h pe=%h busy=%b done=%b err=%b cur=%0d required vj=%h vk=%h pe=%h busy=%b done=%b err=%b cur=%0d",
                     $time, valve_j, valve_k, pump_en, busy, done, err, cur_stage,
                     e.vj, e.vk, e.pe, e.busy, e.done, e.err, e.cur);
        end
        idle_err = e.err;
    end

    // Reference: the cycle-by-cycle trace of one accepted command.
    task automatic push_trace(input int n, input int f, input int m, input int d,
                              input int abort_at, output int len);
        rec_t tr[$];
        rec_t r;
        int fe = (f == 0) ? 1 : f;
        int me = (m == 0) ? 1 : m;
        int de = (d == 0) ? 1 : d;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < fe; k++) begin
                r = idle_rec(1'b0);
                r.busy = 1'b1; r.cur = i; r.vj[i] = 1'b1; r.vk[i] = 1'b1;
                tr.push_back(r);
            end
            for (int k = 0; k < me; k++) begin
                r = idle_rec(1'b0);
                r.busy = 1'b1; r.cur = i; r.pe[i] = 1'b1;
                tr.push_back(r);
            end
        end
        for (int k = 0; k < de; k++) begin
            r = idle_rec(1'b0);
            r.busy = 1'b1; r.cur = n; r.vj[n] = 1'b1;
            tr.push_back(r);
        end
        r = idle_rec(1'b0);
        r.done = 1'b1;
        tr.push_back(r);
        if (abort_at > 0) begin
            while (tr.size() > abort_at) void'(tr.pop_back());
            r = idle_rec(1'b1);
            r.busy = 1'b1; r.cur_dc = 1'b1;
            tr.push_back(r);
        end
        len = tr.size();
        foreach (tr[i]) exp_q.push_back(tr[i]);
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (valve_j !== '0 || valve_k !== '0 || pump_en !== '0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || cur_stage !== '0) begin
            n_fail++;
            $display("FAIL %s got vj=%h vk=%h pe=%h busy=%b done=%b err=%b cur=%0d required all zero",
                     name, valve_j, valve_k, pump_en, busy, done, err, cur_stage);
        end
    endtask

    task automatic randomize_inputs();
        stage_count  = SW'($urandom);
        fill_cycles  = CNT_W'($urandom);
        mix_cycles   = CNT_W'($urandom);
        drain_cycles = CNT_W'($urandom);
    endtask

    // Issues one valid command and steps through its whole duration.
    // junk_at: cycle with a (to be ignored) start; abort_at / reset_at: cycle
    // in which abort / rst_n is applied; 0 disables.
    task automatic run_seq(input int n, input int f, input int m, input int d,
                           input int abort_at, input int junk_at, input int reset_at);
        int len;
        stage_count  = SW'(n);
        fill_cycles  = CNT_W'(f);
        mix_cycles   = CNT_W'(m);
        drain_cycles = CNT_W'(d);
        start = 1'b1;
        @(posedge clk);
        push_trace(n, f, m, d, abort_at, len);
        #1;
        start = 1'b0;
        randomize_inputs();
        $display("seq n=%0d f=%0d m=%0d d=%0d abort_at=%0d junk_at=%0d reset_at=%0d cycles=%0d",
                 n, f, m, d, abort_at, junk_at, reset_at, len);
        for (int c = 1; c <= len; c++) begin
            abort = (c == abort_at);
            start = (c == junk_at);
            if (c == reset_at) begin
                rst_n = 1'b0;
                exp_q.delete();
                idle_err = 1'b0;
                #1;
                check_reset_outputs("async_reset");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic bad_start(input int n);
        rec_t r;
        stage_count = SW'(n);
        start = 1'b1;
        @(posedge clk);
        r = idle_rec(1'b1);
        exp_q.push_back(r);
        #1;
        start = 1'b0;
        $display("bad start n=%0d", n);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n, f, m, d, ab, jk, rs, busy_len;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        stage_count  = '0;
        fill_cycles  = '0;
        mix_cycles   = '0;
        drain_cycles = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_seq(3, 2, 4, 3, 0, 5, 0);          // nominal, start while busy
        run_seq(1, 0, 0, 0, 0, 0, 0);          // zero durations
        bad_start(0);
        bad_start(STAGES + 1);
        run_seq(2, 1, 1, 1, 0, 0, 0);          // valid start clears err
        run_seq(STAGES, 1, 1, 1, 0, 0, 0);     // full chain
        run_seq(2, 2, 3, 2, 10, 3, 0);         // abort in last MIX cycle of stage 1

        abort = 1'b1;                          // abort while idle does nothing
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b0;

        run_seq(4, 2, 4, 1, 0, 0, 22);         // reset during MIX of stage 3
        @(posedge clk);
        #1;

        for (int it = 0; it < 25; it++) begin
            n = ($urandom_range(0, 5) == 0) ? STAGES : int'($urandom_range(1, 10));
            f = $urandom_range(0, 4);
            m = $urandom_range(0, 4);
            d = $urandom_range(0, 4);
            busy_len = n * ((f == 0 ? 1 : f) + (m == 0 ? 1 : m)) + (d == 0 ? 1 : d);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, busy_len)) : 0;
            jk = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, busy_len)) : 0;
            rs = 0;
            if (ab == 0 && $urandom_range(0, 7) == 0) rs = $urandom_range(1, busy_len);
            if (ab != 0 && jk > ab) jk = 0;
            run_seq(n, f, m, d, ab, jk, rs);
            if ($urandom_range(0, 3) == 0) bad_start(STAGES + 1 + int'($urandom_range(0, 10)));
            repeat ($urandom_range(0, 3)) begin
                abort = $urandom_range(0, 1) == 1;
                @(posedge clk);
                #1;
            end
            abort = 1'b0;
        end

        run_seq(1, (1 << CNT_W) - 1, 0, 0, 0, 0, 0);   // maximum duration, no wrap

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained got %0d pending entries required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chain_mixer_seq.md
Name: chain_mixer_seq

Overview:
- Parametrised control sequencer for an N-stage serial chain mixer.
- Stage i mixes junction fluid j[i] with reagent k[i] and produces j[i+1].
- Drives the j-junction valves, the k-reagent inlet valves and the per-stage mixing pumps to run fill, mix and drain phases stage by stage.
- Sits between the host command interface and the fluidic actuator drivers; supports runtime-selected active chain length up to STAGES.

Parameters:
- STAGES, 64, maximum number of mixer stages in the chain (≥1).
- CNT_W, 16, width of the phase-duration counters and duration inputs.
- SW, $clog2(STAGES+1), width of stage_count and cur_stage (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sequence; sampled only in IDLE.
- abort  in  1  terminate the sequence in progress.
- stage_count  in  SW  number of active stages; latched at start.
- fill_cycles  in  CNT_W  fill phase duration; latched at start.
- mix_cycles  in  CNT_W  mix phase duration; latched at start.
- drain_cycles  in  CNT_W  final drain duration; latched at start.
- valve_j  out  STAGES+1  junction valves; bit i opens j[i].
- valve_k  out  STAGES  reagent inlet valves; bit i opens k[i].
- pump_en  out  STAGES  mixing pump enable for stage i.
- busy  out  1  high from the first FILL cycle through DRAIN or ABORT.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag; cleared by the next accepted start.
- cur_stage  out  SW  index of the stage currently being serviced; 0 in IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All valves 0, pump_en 0, busy 0, done 0, err 0, cur_stage 0, counters 0. Applies immediately mid-sequence; no completion pulse is produced.
- All outputs are registered. valve_j, valve_k and pump_en are one-hot or zero; at most one valve group is open in any cycle.
- Durations: a latched value of 0 is treated as 1. Each phase lasts exactly max(d,1) cycles.
- States: IDLE, FILL, MIX, DRAIN, ABORT.
- IDLE:
  - start=1 with 1 ≤ stage_count ≤ STAGES: latch the inputs, clear err, enter FILL at stage 0 next cycle.
  - start=1 with stage_count=0 or stage_count>STAGES: set err=1, stay in IDLE, never assert busy.
- FILL(i): valve_j[i]=1, valve_k[i]=1, everything else 0. After fill_cycles cycles, go to MIX(i).
- MIX(i): pump_en[i]=1, all valves closed. After mix_cycles cycles:
  - i+1 < stage_count: go to FILL(i+1).
  - otherwise: go to DRAIN.
- DRAIN: valve_j[stage_count]=1, cur_stage=stage_count. After drain_cycles cycles, go to IDLE and pulse done for 1 cycle, coincident with busy falling.
- Abort:
  - abort=1 in FILL, MIX or DRAIN: next cycle enter ABORT. All valves and pumps are 0, err=1, busy stays 1 for that single cycle, then IDLE. No done pulse.
  - abort=1 in IDLE: ignored.
  - abort has priority over a phase completing in the same cycle.
- start while busy is ignored; the latched parameters do not change mid-sequence.
- Total latency from the start sample to done: N·(F+M) + D + 1 cycles, where N = stage_count and F, M, D are the effective durations. The first FILL output appears the cycle after start.
- Counters: down-counters loaded with max(d,1)−1; the phase ends when the counter reaches 0. There is no wrap; CNT_W-bit maximum durations must work (2^CNT_W−1 cycles).
- stage_count=STAGES: the last stage is STAGES−1 and DRAIN opens valve_j[STAGES], the top bit.

Test Plan:
- Reset mid-MIX of stage 3 (rst_n low for 1 cycle) → all outputs 0 immediately; IDLE after release; no done.
- start with stage_count=3, fill=2, mix=4, drain=3 → first output the cycle after start, then:
  - valve_j[0]/valve_k[0] for 2 cycles, then pump_en[0] for 4 cycles;
  - the same pattern for stages 1 and 2;
  - valve_j[3] for 3 cycles;
  - done pulse 22 cycles after the start sample; busy high for exactly 21 cycles.
- Zero durations, stage_count=1 (all durations 0) → FILL, MIX and DRAIN each last 1 cycle; done 4 cycles after start.
- Bad length: stage_count=0, then stage_count=STAGES+1 → err=1 each time, busy never rises; a following valid start clears err.
- Full chain: stage_count=64 (STAGES=64), fill=mix=drain=1 → cur_stage steps 0..63, then 64 with valve_j[64] high; done at cycle 130.
- Abort priority: abort asserted in the final MIX cycle of stage 1 (count=2) → ABORT for 1 cycle with all actuators 0, err=1, no DRAIN, no done. A start during busy is ignored and start timing is unaffected.
